// File: rtl/cpu_pkg.sv
// Shared CPU definitions: bus geometry defaults and the bus RAM state type.
package cpu_pkg;

    localparam int CPU_DW = 8;
    localparam int CPU_AW = 8;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } ram_state_e;

endpackage

// File: rtl/ram_core.sv
// DEPTH x DW storage with one synchronous write port and one registered read port.
// Reads of addresses beyond DEPTH return zero; only the read register is reset.
module ram_core
    import cpu_pkg::*;
#(
    parameter int DW    = CPU_DW,
    parameter int AW    = CPU_AW,
    parameter int DEPTH = 2 ** AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    logic [DW-1:0] r_mem [0:DEPTH-1];
    logic [DW-1:0] r_rdata;
    logic          w_rd_in_range;

    assign w_rd_in_range = ({1'b0, raddr} < DEPTH_W);

    // Array write; the array itself carries no reset.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Registered read; out-of-range addresses yield zero instead of an array access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (re) begin
            r_rdata <= w_rd_in_range ? r_mem[raddr] : '0;
        end
    end

    assign rdata = r_rdata;

endmodule

// File: rtl/bus_ram.sv
// Bus-attached RAM: post-reset clear sequencer, strobe decode, sticky protocol
// error flag and the tri-state driver onto the shared CPU data bus.
module bus_ram
    import cpu_pkg::*;
#(
    parameter int DW             = CPU_DW,
    parameter int AW             = CPU_AW,
    parameter int DEPTH          = 2 ** AW,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] addr,
    input  logic          wm,
    input  logic          wb,
    inout  wire  [DW-1:0] data,
    output logic          ready,
    output logic          err
);

    localparam logic [AW:0]  DEPTH_W   = (AW + 1)'(DEPTH);
    localparam logic [AW:0]  LAST_PTR  = (AW + 1)'(DEPTH - 1);
    localparam ram_state_e   RST_STATE = CLEAR_ON_RESET ? CLEAR : IDLE;

    ram_state_e    r_state;
    logic          r_ready;
    logic [AW:0]   r_clr_ptr;
    logic          r_drv;
    logic          r_err;

    logic          w_idle;
    logic          w_in_range;
    logic          w_wr_req;
    logic          w_rd_req;
    logic          w_both;
    logic          w_we;
    logic [AW-1:0] w_waddr;
    logic [DW-1:0] w_wdata;
    logic [DW-1:0] w_rdata;

    assign w_idle     = (r_state == IDLE);
    assign w_in_range = ({1'b0, addr} < DEPTH_W);
    assign w_wr_req   = w_idle & wm & ~wb;
    assign w_rd_req   = w_idle & wb & ~wm;
    assign w_both     = w_idle & wm & wb;

    // Write port mux: the clear sequencer owns the port until IDLE, then the bus does.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = addr;
        w_wdata = data;
        if (r_state == CLEAR) begin
            w_we    = 1'b1;
            w_waddr = r_clr_ptr[AW-1:0];
            w_wdata = '0;
        end else begin
            w_we = w_wr_req & w_in_range;
        end
    end

    // Clear/idle FSM with registered ready; the pointer is one bit wider so DEPTH-1 never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= RST_STATE;
            r_ready   <= ~CLEAR_ON_RESET;
            r_clr_ptr <= '0;
        end else begin
            case (r_state)
                CLEAR: begin
                    if (r_clr_ptr == LAST_PTR) begin
                        r_state <= IDLE;
                        r_ready <= 1'b1;
                    end else begin
                        r_clr_ptr <= r_clr_ptr + 1'b1;
                    end
                end
                IDLE: begin
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= RST_STATE;
                    r_ready <= ~CLEAR_ON_RESET;
                end
            endcase
        end
    end

    // Bus drive enable for one cycle per accepted read, and the sticky protocol error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drv <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_drv <= w_rd_req;
            if (w_both || ((w_wr_req || w_rd_req) && !w_in_range)) begin
                r_err <= 1'b1;
            end
        end
    end

    ram_core #(
        .DW    (DW),
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (w_we),
        .waddr (w_waddr),
        .wdata (w_wdata),
        .re    (w_rd_req),
        .raddr (addr),
        .rdata (w_rdata)
    );

    assign data  = r_drv ? w_rdata : 'z;
    assign ready = r_ready;
    assign err   = r_err;

endmodule

// File: tb/tb_bus_ram.sv
// Bench for bus_ram: three configurations sharing clock and reset. The buses are
// pulled up, so an undriven bus reads as all ones.
module tb_bus_ram;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Instance A: DEPTH 16, clear on reset
    logic [3:0]  a_addr;
    logic        a_wm, a_wb, a_en, a_ready, a_err;
    logic [7:0]  a_drv;
    tri1  [7:0]  bus_a;
    assign bus_a = a_en ? a_drv : 'z;

    // Instance B: DEPTH 200 with 8-bit address, clear on reset
    logic [7:0]  b_addr;
    logic        b_wm, b_wb, b_en, b_ready, b_err;
    logic [7:0]  b_drv;
    tri1  [7:0]  bus_b;
    assign bus_b = b_en ? b_drv : 'z;

    // Instance C: 16-bit words, no clear
    logic [3:0]  c_addr;
    logic        c_wm, c_wb, c_en, c_ready, c_err;
    logic [15:0] c_drv;
    tri1  [15:0] bus_c;
    assign bus_c = c_en ? c_drv : 'z;

    bus_ram #(.DW(8), .AW(4), .DEPTH(16), .CLEAR_ON_RESET(1'b1)) u_a (
        .clk(clk), .rst_n(rst_n), .addr(a_addr), .wm(a_wm), .wb(a_wb),
        .data(bus_a), .ready(a_ready), .err(a_err));

    bus_ram #(.DW(8), .AW(8), .DEPTH(200), .CLEAR_ON_RESET(1'b1)) u_b (
        .clk(clk), .rst_n(rst_n), .addr(b_addr), .wm(b_wm), .wb(b_wb),
        .data(bus_b), .ready(b_ready), .err(b_err));

    bus_ram #(.DW(16), .AW(4), .DEPTH(16), .CLEAR_ON_RESET(1'b0)) u_c (
        .clk(clk), .rst_n(rst_n), .addr(c_addr), .wm(c_wm), .wb(c_wb),
        .data(bus_c), .ready(c_ready), .err(c_err));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Each cycle task sets strobes at the negedge, lets the posedge sample them,
    // then releases the bench's bus driver so the DUT's drive is visible.
    task automatic a_cyc(input logic wm, input logic wb, input logic [3:0] ad, input logic [7:0] d);
        @(negedge clk);
        a_wm = wm; a_wb = wb; a_addr = ad; a_drv = d; a_en = wm;
        @(posedge clk);
        #1 a_en = 1'b0;
        #1;
    endtask

    task automatic b_cyc(input logic wm, input logic wb, input logic [7:0] ad, input logic [7:0] d);
        @(negedge clk);
        b_wm = wm; b_wb = wb; b_addr = ad; b_drv = d; b_en = wm;
        @(posedge clk);
        #1 b_en = 1'b0;
        #1;
    endtask

    task automatic c_cyc(input logic wm, input logic wb, input logic [3:0] ad, input logic [15:0] d);
        @(negedge clk);
        c_wm = wm; c_wb = wb; c_addr = ad; c_drv = d; c_en = wm;
        @(posedge clk);
        #1 c_en = 1'b0;
        #1;
    endtask

    task automatic wait_a_ready(output int n);
        n = 0;
        while (!a_ready && n < 100) begin
            @(posedge clk);
            #1 n++;
        end
    endtask

    task automatic wait_b_ready();
        int k = 0;
        while (!b_ready && k < 400) begin
            @(posedge clk);
            #1 k++;
        end
        chk("b_ready", 32'(b_ready), 32'd1);
    endtask

    logic [7:0] mem_m [0:199];
    logic       err_m;

    initial begin
        int n;
        logic prev_rd;
        rst_n = 1'b0;
        a_wm = 0; a_wb = 0; a_en = 0; a_addr = '0; a_drv = '0;
        b_wm = 0; b_wb = 0; b_en = 0; b_addr = '0; b_drv = '0;
        c_wm = 0; c_wb = 0; c_en = 0; c_addr = '0; c_drv = '0;
        #12;
        chk("rst_a_ready", 32'(a_ready), 32'd0);
        chk("rst_a_err",   32'(a_err),   32'd0);
        chk("rst_a_bus",   32'(bus_a),   32'hFF);
        chk("rst_b_ready", 32'(b_ready), 32'd0);
        chk("rst_c_ready", 32'(c_ready), 32'd1);
        chk("rst_c_bus",   32'(bus_c),   32'hFFFF);

        @(negedge clk) rst_n = 1'b1;
        wait_a_ready(n);
        chk("clr_len1", 32'(n), 32'd16);

        // Pre-fill A with 0xFF, then reset part-way through a clear
        for (int i = 0; i < 16; i++) a_cyc(1'b1, 1'b0, 4'(i), 8'hFF);
        a_cyc(1'b0, 1'b0, 4'd0, 8'h00);
        @(negedge clk) rst_n = 1'b0;
        #2;
        @(negedge clk) rst_n = 1'b1;
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midclr_ready", 32'(a_ready), 32'd0);
        chk("midclr_bus",   32'(bus_a),   32'hFF);
        chk("midclr_c_rdy", 32'(c_ready), 32'd1);
        @(negedge clk) rst_n = 1'b1;
        wait_a_ready(n);
        chk("clr_len2", 32'(n), 32'd16);
        for (int i = 0; i < 16; i++) begin
            a_cyc(1'b0, 1'b1, 4'(i), 8'h00);
            chk("clr_rd", 32'(bus_a), 32'h00);
        end
        a_cyc(1'b0, 1'b0, 4'd0, 8'h00);

        // Write/read, single-cycle drive, back-to-back reads
        a_cyc(1'b1, 1'b0, 4'd3, 8'hA5);
        chk("wr_nodrv", 32'(bus_a), 32'hFF);
        a_cyc(1'b1, 1'b0, 4'd4, 8'h5A);
        a_cyc(1'b0, 1'b1, 4'd3, 8'h00);
        chk("rd3", 32'(bus_a), 32'hA5);
        a_cyc(1'b0, 1'b0, 4'd3, 8'h00);
        chk("rd3_release", 32'(bus_a), 32'hFF);
        a_cyc(1'b0, 1'b1, 4'd3, 8'h00);
        chk("b2b_3", 32'(bus_a), 32'hA5);
        a_cyc(1'b0, 1'b1, 4'd4, 8'h00);
        chk("b2b_4", 32'(bus_a), 32'h5A);
        a_cyc(1'b0, 1'b0, 4'd0, 8'h00);
        a_cyc(1'b1, 1'b0, 4'd6, 8'h3C);
        a_cyc(1'b0, 1'b1, 4'd6, 8'h00);
        chk("wr_then_rd", 32'(bus_a), 32'h3C);
        a_cyc(1'b0, 1'b0, 4'd0, 8'h00);

        // Both strobes high
        a_cyc(1'b1, 1'b0, 4'd5, 8'h11);
        chk("err_before", 32'(a_err), 32'd0);
        a_cyc(1'b1, 1'b1, 4'd5, 8'h22);
        chk("both_err", 32'(a_err), 32'd1);
        chk("both_nodrv", 32'(bus_a), 32'hFF);
        a_cyc(1'b0, 1'b0, 4'd5, 8'h00);
        chk("err_sticky", 32'(a_err), 32'd1);
        a_cyc(1'b0, 1'b1, 4'd5, 8'h00);
        chk("both_nowrite", 32'(bus_a), 32'h11);
        a_cyc(1'b0, 1'b0, 4'd0, 8'h00);

        // No-clear 16-bit instance
        c_cyc(1'b1, 1'b0, 4'd9, 16'hBEEF);
        c_cyc(1'b0, 1'b1, 4'd9, 16'h0000);
        chk("c_rd", 32'(bus_c), 32'hBEEF);
        c_cyc(1'b0, 1'b0, 4'd0, 16'h0000);
        chk("c_release", 32'(bus_c), 32'hFFFF);
        chk("c_err", 32'(c_err), 32'd0);

        // Out-of-range on DEPTH 200
        wait_b_ready();
        chk("b_err0", 32'(b_err), 32'd0);
        b_cyc(1'b0, 1'b1, 8'd250, 8'h00);
        chk("oor_rd", 32'(bus_b), 32'h00);
        chk("oor_err", 32'(b_err), 32'd1);
        b_cyc(1'b0, 1'b0, 8'd0, 8'h00);
        b_cyc(1'b1, 1'b0, 8'd250, 8'h77);
        b_cyc(1'b0, 1'b1, 8'd50, 8'h00);
        chk("oor_alias50", 32'(bus_b), 32'h00);
        b_cyc(1'b0, 1'b1, 8'd122, 8'h00);
        chk("oor_alias122", 32'(bus_b), 32'h00);
        b_cyc(1'b0, 1'b1, 8'd199, 8'h00);
        chk("rd_last", 32'(bus_b), 32'h00);
        b_cyc(1'b0, 1'b0, 8'd0, 8'h00);

        // Fresh reset, then random traffic on B against the reference model
        @(negedge clk) rst_n = 1'b0;
        #2;
        @(negedge clk) rst_n = 1'b1;
        wait_b_ready();
        for (int i = 0; i < 200; i++) mem_m[i] = 8'h00;
        err_m   = 1'b0;
        prev_rd = 1'b0;
        for (int i = 0; i < 120; i++) begin
            int         op;
            logic       wm, wb;
            logic [7:0] ad, d, exp;
            op = int'($urandom_range(0, 9));
            ad = 8'($urandom_range(0, 255));
            d  = 8'($urandom);
            wm = (op < 4) || (op == 8);
            wb = (op >= 4 && op < 8) || (op == 8);
            if (prev_rd && wm) b_cyc(1'b0, 1'b0, 8'd0, 8'h00);
            b_cyc(wm, wb, ad, d);
            exp = 8'hFF;
            if (wm && wb) begin
                err_m = 1'b1;
            end else if (wm) begin
                if (ad < 200) mem_m[ad] = d;
                else err_m = 1'b1;
            end else if (wb) begin
                exp = (ad < 200) ? mem_m[ad] : 8'h00;
                if (ad >= 200) err_m = 1'b1;
            end
            chk("rnd_bus", 32'(bus_b), 32'(exp));
            chk("rnd_err", 32'(b_err), 32'(err_m));
            prev_rd = wb && !wm;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/bus_ram.md
# bus_ram

Parametrised single-port RAM on the CPU's shared tri-state data bus. It replaces the fixed 8-bit × 256 memory with configurable width and depth, a registered read path, an optional clear sequence after reset, and a sticky error flag for bus-protocol violations. It sits on the CPU data bus beside the register file and ALU output drivers. The control unit sequences it with the same `wm`/`wb` strobes as before, and additionally gates accesses on `ready`.

## Interface
Parameters:
- `DW`, default 8: data word width and bus width.
- `AW`, default 8: address width.
- `DEPTH`, default 2**AW: number of words; legal range 2..2**AW.
- `CLEAR_ON_RESET`, default 1: if 1, the memory is zero-filled after reset; if 0, contents are left untouched.

Ports:
- `clk` in 1: single clock; everything is posedge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `addr` in AW: word address, sampled at posedge.
- `wm` in 1: write the bus value into memory.
- `wb` in 1: drive the memory word onto the bus.
- `data` inout DW: shared bus, tri-stated when not driving.
- `ready` out 1: high when accesses are accepted.
- `err` out 1: sticky flag for a protocol violation.

## Operation
- FSM states:
  - `CLEAR`: entered on reset when `CLEAR_ON_RESET`=1. It writes 0 to word `clr_ptr` each cycle, with `clr_ptr` running 0..DEPTH-1. After writing word DEPTH-1 it moves to `IDLE`.
  - `IDLE`: normal operation. Reset is the only exit.
- With `CLEAR_ON_RESET`=0, reset goes straight to `IDLE`.
- `ready` = (state==`IDLE`). In `CLEAR`, `wm`/`wb` are ignored, the bus is never driven, and `err` does not change.
- Write: at a posedge in `IDLE` with `wm`=1, `wb`=0 and addr<DEPTH, `mem[addr]` <= `data`.
- Read: at a posedge in `IDLE` with `wb`=1, `wm`=0:
  - `rdata_q` <= `mem[addr]` (0 if addr≥DEPTH);
  - `drv_q` <= 1.
- At any other posedge, `drv_q` <= 0.
- `data` = `drv_q` ? `rdata_q` : 'z.
- Out-of-range address (addr≥DEPTH, only possible when DEPTH<2**AW):
  - write is dropped;
  - read returns 0;
  - `err` is set.
- `wm` and `wb` both high in `IDLE`: no write, no read, `drv_q` <= 0, `err` <= 1.
- `err` stays set until reset.
- Memory array has no reset. Only the FSM, `clr_ptr`, `drv_q`, `rdata_q` and `err` are reset.

## Timing
- Reset values:
  - `ready`=0 if `CLEAR_ON_RESET`, else 1;
  - `err`=0;
  - `drv_q`=0, so `data`=z;
  - `rdata_q`=0;
  - `clr_ptr`=0.
- Clear takes exactly DEPTH cycles after `rst_n` deasserts. `ready` rises after the posedge that writes word DEPTH-1.
- Read latency is 1. The strobe is sampled at edge N and the bus is valid from just after edge N until edge N+1.
- Holding `wb` with a changing `addr` gives back-to-back reads, one word per cycle, and the bus is driven continuously.
- Write-then-read of the same address on consecutive edges returns the new value.
- Read and write never share an edge, so read-during-write is undefined-free by construction.
- Reset asserted mid-clear or mid-read does two things at once, asynchronously:
  - the bus is released;
  - the FSM is forced to `CLEAR` with `clr_ptr`=0, so the clear restarts.
- `clr_ptr` width is AW+1, so the terminal compare against DEPTH-1 never wraps when DEPTH=2**AW.

## Structure
- Shared package `cpu_pkg` holds:
  - typedef `ram_state_e` {`CLEAR`, `IDLE`};
  - localparam defaults `CPU_DW`=8, `CPU_AW`=8.
- Sub-module `ram_core`: DEPTH×DW array with one synchronous write port and one synchronous read port (we, waddr, wdata, re, raddr, rdata).
- `bus_ram` contains:
  - the FSM, clear counter, strobe decode and write mux (clear vs bus);
  - the `err` flag;
  - the tri-state driver.

## Test plan
- Reset clear, `DEPTH`=16, `CLEAR_ON_RESET`=1, memory pre-filled with 0xFF:
  - release `rst_n` → `ready` low for exactly 16 cycles;
  - afterwards every read returns 0x00.
- Write/read:
  - write 0xA5 to addr 3, then pulse `wb` at addr 3 → bus shows 0xA5 for exactly one cycle after the edge, then z;
  - hold `wb` across addrs 3,4 → values appear back-to-back.
- Protocol error: `wm`=`wb`=1 at addr 5 holding 0x11, bus forced to 0x22 → mem[5] stays 0x11, bus undriven, `err`=1 and stays 1 after both strobes drop.
- Out of range, `DEPTH`=200, `AW`=8:
  - write 0x77 to addr 250 → no write;
  - read addr 250 → 0x00 on the bus, `err`=1.
- Reset mid-clear: assert `rst_n` low at clear cycle 7 → bus z, `ready`=0; after release, clear takes the full DEPTH cycles again.
- `CLEAR_ON_RESET`=0, `DW`=16: `ready`=1 immediately after reset; a write of 0xBEEF reads back as 0xBEEF.
